// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the RV32I multicycle control unit: opcodes, FSM states,
// instruction classes and the EXECUTE strobe bundle produced by the main decoder.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM_RD  = 3'd4,
        ST_MEM_WR  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
        CLS_LOAD, CLS_STORE, CLS_MISC_MEM, CLS_SYSTEM, CLS_ILLEGAL
    } instr_class_t;

    localparam logic [2:0] ALU_ADD = 3'b000;

    localparam logic [1:0] WR_SRC_ALU = 2'b00;
    localparam logic [1:0] WR_SRC_CSR = 2'b01;
    localparam logic [1:0] WR_SRC_MEM = 2'b10;
    localparam logic [1:0] WR_SRC_PC4 = 2'b11;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef struct packed {
        logic       alua_src;
        logic       alub_src;
        logic       sub;
        logic       arithmetic;
        logic       alupc_src;
        logic       pc_src;
        logic       pc_en;
        logic       wr_reg_en;
        logic       mem_addr_src;
        logic       ecall;
        logic       illegal;
        logic [2:0] alu_src;
        logic [1:0] wr_reg_src;
    } exec_strobes_t;

    localparam int STROBE_W = $bits(exec_strobes_t);

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational RV32I main decoder: classifies the instruction, checks legality
// and produces the strobes the control unit drives during EXECUTE.
module rv32i_main_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    output logic [3:0]          instr_class,
    output logic                legal,
    output logic [STROBE_W-1:0] strobes
);

    instr_class_t  cls;
    exec_strobes_t s;

    always_comb begin
        cls = CLS_ILLEGAL;
        s   = '0;
        case (opcode)
            OPC_OP: begin
                cls          = CLS_OP;
                s.alu_src    = funct3;
                s.sub        = (funct3 == 3'b000) & funct7[5];
                s.arithmetic = (funct3 == 3'b101) & funct7[5];
                s.wr_reg_en  = 1'b1;
                s.wr_reg_src = WR_SRC_ALU;
                s.pc_en      = 1'b1;
            end
            OPC_OP_IMM: begin
                cls          = CLS_OP_IMM;
                s.alu_src    = funct3;
                s.alub_src   = 1'b1;
                s.arithmetic = (funct3 == 3'b101) & funct7[5];
                s.wr_reg_en  = 1'b1;
                s.wr_reg_src = WR_SRC_ALU;
                s.pc_en      = 1'b1;
            end
            OPC_LUI: begin
                cls         = CLS_LUI;
                s.alub_src  = 1'b1;
                s.alu_src   = ALU_ADD;
                s.wr_reg_en = 1'b1;
                s.pc_en     = 1'b1;
            end
            OPC_AUIPC: begin
                cls         = CLS_AUIPC;
                s.alua_src  = 1'b1;
                s.alub_src  = 1'b1;
                s.alu_src   = ALU_ADD;
                s.wr_reg_en = 1'b1;
                s.pc_en     = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                cls          = (opcode == OPC_JAL) ? CLS_JAL : CLS_JALR;
                s.wr_reg_src = WR_SRC_PC4;
                s.wr_reg_en  = 1'b1;
                s.pc_src     = 1'b1;
                s.alupc_src  = (opcode == OPC_JALR);
                s.pc_en      = 1'b1;
            end
            OPC_BRANCH: begin
                // pc_src for branches is resolved from the ALU flags by the FSM
                if (!(funct3 inside {3'b010, 3'b011})) begin
                    cls       = CLS_BRANCH;
                    s.sub     = 1'b1;
                    s.alu_src = ALU_ADD;
                    s.pc_en   = 1'b1;
                end
            end
            OPC_LOAD, OPC_STORE: begin
                if ((opcode == OPC_LOAD) ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                         : (funct3 inside {3'b000, 3'b001, 3'b010})) begin
                    cls            = (opcode == OPC_LOAD) ? CLS_LOAD : CLS_STORE;
                    s.mem_addr_src = 1'b1;
                    s.alub_src     = 1'b1;
                    s.alu_src      = ALU_ADD;
                end
            end
            OPC_MISC_MEM: begin
                cls     = CLS_MISC_MEM;
                s.pc_en = 1'b1;
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    cls     = CLS_SYSTEM;
                    s.ecall = 1'b1;
                    s.pc_en = 1'b1;
                end
            end
            default: ;
        endcase
        if (cls == CLS_ILLEGAL) begin
            s         = '0;
            s.illegal = 1'b1;
            s.pc_en   = 1'b1;
        end
    end

    assign instr_class = cls;
    assign legal       = (cls != CLS_ILLEGAL);
    assign strobes     = s;

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM: sequences fetch/decode/execute/memory phases,
// runs the memory req/ack handshake and resolves branch outcomes from ALU flags.
//
// state   | meaning
// IDLE    | post-reset, all strobes low, one cycle
// FETCH   | instruction read request until mem_ack, IR load on ack
// DECODE  | IR / register file settle, all strobes low
// EXECUTE | per-class ALU / PC / writeback strobes
// MEM_RD  | load data request until mem_ack, writeback on ack
// MEM_WR  | store request until mem_ack
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry_out,
    input  logic       overflow,
    input  logic       mem_ack,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       alua_src,
    output logic       alub_src,
    output logic       sub,
    output logic       arithmetic,
    output logic       alupc_src,
    output logic       pc_src,
    output logic       pc_en,
    output logic       wr_reg_en,
    output logic       ir_en,
    output logic       mem_addr_src,
    output logic [2:0] alu_src,
    output logic [1:0] wr_reg_src,
    output logic       ecall,
    output logic       illegal_instruction
);

    if (DATA_SIZE != 32) begin : g_size_check
        $error("multicycle_control_unit supports only DATA_SIZE = 32");
    end

    state_t                state, state_next;
    logic [3:0]            class_bits;
    logic                  legal;
    logic [STROBE_W-1:0]   strobe_bits;
    instr_class_t          cls;
    exec_strobes_t         ex;
    logic                  branch_taken;

    rv32i_main_decoder u_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .instr_class (class_bits),
        .legal       (legal),
        .strobes     (strobe_bits)
    );

    assign cls = instr_class_t'(class_bits);
    assign ex  = exec_strobes_t'(strobe_bits);

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = negative ^ overflow;
            3'b101:  branch_taken = ~(negative ^ overflow);
            3'b110:  branch_taken = ~carry_out;
            3'b111:  branch_taken = carry_out;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    state_next = ST_FETCH;
            ST_FETCH:   if (mem_ack) state_next = ST_DECODE;
            ST_DECODE:  state_next = ST_EXECUTE;
            ST_EXECUTE: begin
                if (legal && cls == CLS_LOAD)       state_next = ST_MEM_RD;
                else if (legal && cls == CLS_STORE) state_next = ST_MEM_WR;
                else                                state_next = ST_FETCH;
            end
            ST_MEM_RD, ST_MEM_WR: if (mem_ack) state_next = ST_FETCH;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Reset gates every strobe so a mid-handshake reset drops the request at once
    always_comb begin
        mem_rd_en           = 1'b0;
        mem_wr_en           = 1'b0;
        mem_size            = MEM_SIZE_B;
        mem_unsigned        = 1'b0;
        alua_src            = 1'b0;
        alub_src            = 1'b0;
        sub                 = 1'b0;
        arithmetic          = 1'b0;
        alupc_src           = 1'b0;
        pc_src              = 1'b0;
        pc_en               = 1'b0;
        wr_reg_en           = 1'b0;
        ir_en               = 1'b0;
        mem_addr_src        = 1'b0;
        alu_src             = ALU_ADD;
        wr_reg_src          = WR_SRC_ALU;
        ecall               = 1'b0;
        illegal_instruction = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    mem_rd_en = 1'b1;
                    mem_size  = MEM_SIZE_W;
                    ir_en     = mem_ack;
                end
                ST_EXECUTE: begin
                    alua_src            = ex.alua_src;
                    alub_src            = ex.alub_src;
                    sub                 = ex.sub;
                    arithmetic          = ex.arithmetic;
                    alupc_src           = ex.alupc_src;
                    pc_src              = (cls == CLS_BRANCH) ? branch_taken : ex.pc_src;
                    pc_en               = ex.pc_en;
                    wr_reg_en           = ex.wr_reg_en;
                    mem_addr_src        = ex.mem_addr_src;
                    alu_src             = ex.alu_src;
                    wr_reg_src          = ex.wr_reg_src;
                    ecall               = ex.ecall;
                    illegal_instruction = ex.illegal;
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    mem_addr_src = 1'b1;
                    alub_src     = 1'b1;
                    mem_size     = funct3[1:0];
                    pc_en        = mem_ack;
                    if (state == ST_MEM_RD) begin
                        mem_rd_en    = 1'b1;
                        mem_unsigned = funct3[2];
                        wr_reg_en    = mem_ack;
                        wr_reg_src   = mem_ack ? WR_SRC_MEM : WR_SRC_ALU;
                    end else begin
                        mem_wr_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: builds a per-cycle expected trace for each instruction from
// the ISA rules (real operand comparisons for branches) and compares every cycle.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       mem_rd_en;
        logic       mem_wr_en;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       alua_src;
        logic       alub_src;
        logic       sub;
        logic       arithmetic;
        logic       alupc_src;
        logic       pc_src;
        logic       pc_en;
        logic       wr_reg_en;
        logic       ir_en;
        logic       mem_addr_src;
        logic [2:0] alu_src;
        logic [1:0] wr_reg_src;
        logic       ecall;
        logic       illegal_instruction;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       ack;
        logic [3:0] flags;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        out_t       exp;
    } cyc_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic zero = 1'b0, negative = 1'b0, carry_out = 1'b0, overflow = 1'b0;
    logic mem_ack = 1'b0;
    out_t act;
    logic mem_rd_en, mem_wr_en, mem_unsigned, alua_src, alub_src, sub, arithmetic;
    logic alupc_src, pc_src, pc_en, wr_reg_en, ir_en, mem_addr_src, ecall, illegal_instruction;
    logic [1:0] mem_size, wr_reg_src;
    logic [2:0] alu_src;

    cyc_t q[$];
    out_t exp_cur = '0;
    logic exp_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    always #5 clock = ~clock;

    multicycle_control_unit #(.DATA_SIZE(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
        .mem_ack(mem_ack), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .alua_src(alua_src), .alub_src(alub_src), .sub(sub),
        .arithmetic(arithmetic), .alupc_src(alupc_src), .pc_src(pc_src), .pc_en(pc_en),
        .wr_reg_en(wr_reg_en), .ir_en(ir_en), .mem_addr_src(mem_addr_src), .alu_src(alu_src),
        .wr_reg_src(wr_reg_src), .ecall(ecall), .illegal_instruction(illegal_instruction)
    );

    assign act = {mem_rd_en, mem_wr_en, mem_size, mem_unsigned, alua_src, alub_src, sub,
                  arithmetic, alupc_src, pc_src, pc_en, wr_reg_en, ir_en, mem_addr_src,
                  alu_src, wr_reg_src, ecall, illegal_instruction};

    // ALU flags of a - b as the datapath would produce them: {zero, negative, carry, overflow}
    function automatic logic [3:0] flags_of(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d = {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {d[31:0] == 32'd0, d[31], d[32], (a[31] != b[31]) && (d[31] != a[31])};
    endfunction

    // EXECUTE-cycle outputs from the ISA rules; kind: 0 retire, 1 load, 2 store
    function automatic out_t model_exec(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b, output int kind);
        out_t o;
        logic ill;
        logic taken;
        o = '0; kind = 0; ill = 1'b0; taken = 1'b0;
        case (op)
            7'b0110011, 7'b0010011: begin
                o.alu_src    = f3;
                o.alub_src   = (op == 7'b0010011);
                o.sub        = (op == 7'b0110011) && f3 == 3'd0 && f7[5];
                o.arithmetic = f3 == 3'd5 && f7[5];
                o.wr_reg_en  = 1'b1;
                o.pc_en      = 1'b1;
            end
            7'b0110111: begin o.alub_src = 1; o.wr_reg_en = 1; o.pc_en = 1; end
            7'b0010111: begin o.alua_src = 1; o.alub_src = 1; o.wr_reg_en = 1; o.pc_en = 1; end
            7'b1101111, 7'b1100111: begin
                o.wr_reg_src = 2'b11; o.wr_reg_en = 1; o.pc_src = 1; o.pc_en = 1;
                o.alupc_src  = (op == 7'b1100111);
            end
            7'b1100011: begin
                case (f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) < $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a < b);
                    3'd7: taken = (a >= b);
                    default: ill = 1'b1;
                endcase
                if (!ill) begin o.sub = 1; o.pc_en = 1; o.pc_src = taken; end
            end
            7'b0000011: if (f3 == 3 || f3 > 5) ill = 1'b1; else kind = 1;
            7'b0100011: if (f3 > 2) ill = 1'b1; else kind = 2;
            7'b0001111: o.pc_en = 1;
            7'b1110011: if (f3 == 0 && f7 == 0) begin o.ecall = 1; o.pc_en = 1; end else ill = 1'b1;
            default: ill = 1'b1;
        endcase
        if (kind != 0) begin o.mem_addr_src = 1; o.alub_src = 1; end
        if (ill) begin o = '0; o.illegal_instruction = 1; o.pc_en = 1; end
        return o;
    endfunction

    function automatic cyc_t mkc(input logic rst, input logic ack, input logic [3:0] fl,
                                 input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input out_t e);
        cyc_t c;
        c.rst = rst; c.ack = ack; c.flags = fl; c.op = op; c.f3 = f3; c.f7 = f7; c.exp = e;
        return c;
    endfunction

    function automatic out_t fetch_exp(input logic ack);
        out_t e;
        e = '0; e.mem_rd_en = 1; e.mem_size = 2'b10; e.ir_en = ack;
        return e;
    endfunction

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++)
            q.push_back(mkc(1'b1, 1'($urandom), 4'($urandom), 7'($urandom), 3'($urandom), 7'($urandom), '0));
        q.push_back(mkc(1'b0, 1'($urandom), 4'($urandom), 7'($urandom), 3'($urandom), 7'($urandom), '0));
    endtask

    task automatic add_fetch_stall(input int n);
        for (int i = 0; i < n; i++)
            q.push_back(mkc(1'b0, 1'b0, 4'($urandom), 7'($urandom), 3'($urandom), 7'($urandom), fetch_exp(1'b0)));
    endtask

    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fw, input int mw, input logic [31:0] a, input logic [31:0] b);
        out_t e;
        int kind;
        add_fetch_stall(fw);
        q.push_back(mkc(1'b0, 1'b1, 4'($urandom), op, f3, f7, fetch_exp(1'b1)));
        q.push_back(mkc(1'b0, 1'($urandom), 4'($urandom), op, f3, f7, '0));
        e = model_exec(op, f3, f7, a, b, kind);
        q.push_back(mkc(1'b0, 1'($urandom), flags_of(a, b), op, f3, f7, e));
        if (kind != 0) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0;
                e.mem_addr_src = 1; e.alub_src = 1; e.mem_size = f3[1:0];
                e.mem_rd_en = (kind == 1); e.mem_wr_en = (kind == 2);
                e.mem_unsigned = (kind == 1) && f3[2];
                if (i == mw) begin
                    e.pc_en = 1;
                    if (kind == 1) begin e.wr_reg_en = 1; e.wr_reg_src = 2'b10; end
                end
                q.push_back(mkc(1'b0, i == mw, 4'($urandom), op, f3, f7, e));
            end
        end
    endtask

    task automatic pin_model(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL model_%s actual %h required %h", name, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (exp_valid) begin
                checks++;
                if (act !== exp_cur) begin
                    errors++;
                    $display("FAIL outputs cycle %0d op=%b f3=%b rst=%b: actual %h required %h",
                             cycle_no, opcode, funct3, reset, act, exp_cur);
                end
            end
        end
    end

    initial begin
        logic [6:0] ops [11];
        out_t want, got;
        int k;
        logic [6:0] op, f7;
        logic [31:0] a, b;

        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111, 7'b1110011};

        want = '0; want.sub = 1; want.wr_reg_en = 1; want.pc_en = 1;
        got = model_exec(7'b0110011, 3'd0, 7'b0100000, 0, 0, k);
        pin_model("sub", got, want);
        want = '0; want.sub = 1; want.pc_en = 1; want.pc_src = 1;
        got = model_exec(7'b1100011, 3'd6, 7'd0, 32'd1, 32'd2, k);
        pin_model("bltu_taken", got, want);
        want = '0; want.wr_reg_src = 2'b11; want.wr_reg_en = 1; want.pc_src = 1;
        want.alupc_src = 1; want.pc_en = 1;
        got = model_exec(7'b1100111, 3'd0, 7'd0, 0, 0, k);
        pin_model("jalr", got, want);
        want = '0; want.illegal_instruction = 1; want.pc_en = 1;
        got = model_exec(7'b1111111, 3'd0, 7'd0, 0, 0, k);
        pin_model("illegal_op", got, want);
        pin_model("flags_bltu", {28'd0, flags_of(32'd1, 32'd2)}, {28'd0, 4'b0100});

        add_reset(3);
        add_fetch_stall(2);
        add_reset(3);
        add_instr(7'b0110011, 3'd0, 7'b0100000, 0, 0, 0, 0);
        add_instr(7'b0000011, 3'd2, 7'd0, 0, 3, 0, 0);
        add_instr(7'b1100011, 3'd6, 7'd0, 1, 0, 32'd1, 32'd2);
        add_instr(7'b1100011, 3'd6, 7'd0, 0, 0, 32'd9, 32'd2);
        add_instr(7'b1100111, 3'd0, 7'd0, 0, 0, 0, 0);
        add_instr(7'b1111111, 3'd0, 7'd0, 0, 0, 0, 0);
        add_instr(7'b1110011, 3'd0, 7'd0, 0, 0, 0, 0);
        add_instr(7'b1110011, 3'd1, 7'd0, 0, 0, 0, 0);
        add_instr(7'b0100011, 3'd1, 7'd0, 2, 1, 0, 0);
        add_instr(7'b0000011, 3'd4, 7'd0, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                add_fetch_stall($urandom_range(0, 3));
                add_reset($urandom_range(1, 3));
            end
            op = ($urandom_range(0, 12) < 11) ? ops[$urandom_range(0, 10)] : 7'($urandom);
            case ($urandom_range(0, 3))
                0:       f7 = 7'd0;
                1:       f7 = 7'b0100000;
                default: f7 = 7'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            add_instr(op, 3'($urandom), f7, $urandom_range(0, 3), $urandom_range(0, 3), a, b);
        end

        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            @(negedge clock);
            cycle_no++;
            reset = c.rst; mem_ack = c.ack;
            {zero, negative, carry_out, overflow} = c.flags;
            opcode = c.op; funct3 = c.f3; funct7 = c.f7;
            exp_cur = c.exp;
            exp_valid = 1'b1;
        end
        @(negedge clock);
        exp_valid = 1'b0;
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
